// File: rtl/fifo_control.sv
// Pointer/flag controller for an external 2^ADDR_WIDTH-entry FIFO memory with registered read data.
// Blocks overflow/underflow attempts and records them in sticky error bits.
module fifo_control #(
    parameter int DATA_WIDTH   = 12,
    parameter int ADDR_WIDTH   = 3,
    parameter int ALMOST_FULL  = 6,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  write,
    output logic                  read,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(ALMOST_FULL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(ALMOST_EMPTY);

    logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_WIDTH:0]   count_reg, count_next;
    logic                  valid_reg;
    logic                  overflow_reg, overflow_next;
    logic                  underflow_reg, underflow_next;

    assign full         = (count_reg == DEPTH_C);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AF_C);
    assign almost_empty = (count_reg <= AE_C);

    // Gating with reset keeps the memory strobes quiet while reset is held.
    assign write = push & ~full & reset;
    assign read  = pop & ~empty & reset;

    assign data = data_in;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg | (push & full);
        underflow_next = underflow_reg | (pop & empty);
        if (write) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (read) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({write, read})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            valid_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            valid_reg     <= read;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // The memory registers q on the same edge that registers valid, so they line up.
    assign data_out   = q;
    assign valid_out  = valid_reg;
    assign wr_ptr     = wr_ptr_reg;
    assign rd_ptr     = rd_ptr_reg;
    assign fifo_count = count_reg;
    assign overflow   = overflow_reg;
    assign underflow  = underflow_reg;

endmodule

// File: tb/tb_fifo_control.sv
// Bench for fifo_control: directed plan plus random traffic, checked against a queue-based model.
module tb_fifo_control;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [11:0] data_in = '0;
    logic [11:0] q;
    logic [11:0] data;
    logic        write, read;
    logic [2:0]  wr_ptr, rd_ptr;
    logic [11:0] data_out;
    logic        valid_out;
    logic [3:0]  fifo_count;
    logic        full, empty, almost_full, almost_empty, overflow, underflow;

    fifo_control dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in), .q(q),
        .data(data), .write(write), .read(read), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
        .data_out(data_out), .valid_out(valid_out), .fifo_count(fifo_count),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Storage memory the controller drives: registered read, no reset.
    logic [11:0] mem [8];
    always @(posedge clk) begin
        if (write) mem[wr_ptr] <= data;
        if (read) q <= mem[rd_ptr];
    end

    // Reference model
    logic [11:0] mq[$];
    int          wr_n, rd_n;
    bit          m_ovf, m_unf, m_valid;
    logic [11:0] m_dout;

    int pass_cnt = 0;
    int total_cnt = 0;
    int fail_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        wr_n = 0; rd_n = 0;
        m_ovf = 0; m_unf = 0; m_valid = 0;
    endtask

    task automatic check_state(input string ph);
        int cnt;
        cnt = mq.size();
        chk({ph, ".count"}, 32'(fifo_count), 32'(cnt));
        chk({ph, ".full"}, 32'(full), 32'(cnt == 8));
        chk({ph, ".empty"}, 32'(empty), 32'(cnt == 0));
        chk({ph, ".afull"}, 32'(almost_full), 32'(cnt >= 6));
        chk({ph, ".aempty"}, 32'(almost_empty), 32'(cnt <= 2));
        chk({ph, ".wr_ptr"}, 32'(wr_ptr), 32'(wr_n % 8));
        chk({ph, ".rd_ptr"}, 32'(rd_ptr), 32'(rd_n % 8));
        chk({ph, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({ph, ".unf"}, 32'(underflow), 32'(m_unf));
        chk({ph, ".valid"}, 32'(valid_out), 32'(m_valid));
        if (m_valid) chk({ph, ".dout"}, 32'(data_out), 32'(m_dout));
    endtask

    // One cycle: drive, check strobes combinationally, clock, check registered outputs.
    task automatic cycle(input string ph, input bit p, input bit o, input logic [11:0] d);
        bit ew, er;
        int cnt;
        push = p; pop = o; data_in = d;
        #1;
        cnt = mq.size();
        ew = p && (cnt < 8);
        er = o && (cnt > 0);
        chk({ph, ".write"}, 32'(write), 32'(ew));
        chk({ph, ".read"}, 32'(read), 32'(er));
        chk({ph, ".data"}, 32'(data), 32'(d));
        @(posedge clk);
        #1;
        if (p && cnt == 8) m_ovf = 1;
        if (o && cnt == 0) m_unf = 1;
        m_valid = er;
        if (er) begin
            m_dout = mq.pop_front();
            rd_n++;
        end
        if (ew) begin
            mq.push_back(d);
            wr_n++;
        end
        $display("%s push=%0d pop=%0d din=%03h count=%0d valid=%0d dout=%03h",
                 ph, p, o, d, fifo_count, valid_out, data_out);
        check_state(ph);
    endtask

    task automatic check_reset_vals(input string ph);
        chk({ph, ".count"}, 32'(fifo_count), 0);
        chk({ph, ".wr_ptr"}, 32'(wr_ptr), 0);
        chk({ph, ".rd_ptr"}, 32'(rd_ptr), 0);
        chk({ph, ".valid"}, 32'(valid_out), 0);
        chk({ph, ".ovf"}, 32'(overflow), 0);
        chk({ph, ".unf"}, 32'(underflow), 0);
        chk({ph, ".empty"}, 32'(empty), 1);
        chk({ph, ".aempty"}, 32'(almost_empty), 1);
        chk({ph, ".full"}, 32'(full), 0);
        chk({ph, ".afull"}, 32'(almost_full), 0);
        chk({ph, ".write"}, 32'(write), 0);
        chk({ph, ".read"}, 32'(read), 0);
    endtask

    initial begin
        int wt_push, wt_pop;
        model_reset();
        // Power-up reset with push/pop requested to confirm the strobes are gated.
        push = 1; pop = 1; data_in = 12'h111;
        @(posedge clk); #1;
        check_reset_vals("por");
        @(posedge clk); #1;
        push = 0; pop = 0;
        reset = 1;
        #1;

        for (int i = 1; i <= 8; i++) cycle("fill", 1, 0, 12'(i));
        chk("fill.full_const", 32'(full), 1);
        chk("fill.wrap_const", 32'(wr_ptr), 0);
        chk("fill.ovf_const", 32'(overflow), 0);

        cycle("ovf", 1, 0, 12'hABC);
        chk("ovf.count_const", 32'(fifo_count), 8);
        cycle("ovf_hold", 0, 0, 12'h000);
        chk("ovf.hold_const", 32'(overflow), 1);

        for (int i = 1; i <= 8; i++) begin
            cycle("drain", 0, 1, 12'h000);
            chk("drain.dout_const", 32'(data_out), 32'(i));
        end
        chk("drain.rdptr_const", 32'(rd_ptr), 0);

        cycle("empty_pp", 1, 1, 12'h5A5);
        chk("empty_pp.unf_const", 32'(underflow), 1);
        chk("empty_pp.count_const", 32'(fifo_count), 1);
        cycle("empty_pp_pop", 0, 1, 12'h000);
        chk("empty_pp.dout_const", 32'(data_out), 32'h5A5);

        for (int i = 0; i < 4; i++) cycle("half_fill", 1, 0, 12'($urandom));
        for (int i = 0; i < 10; i++) cycle("half_pp", 1, 1, 12'($urandom));
        chk("half.count_const", 32'(fifo_count), 4);

        cycle("to5", 1, 0, 12'($urandom));
        // Reset mid-pop, asserted between edges.
        push = 0; pop = 1;
        reset = 0;
        #1;
        model_reset();
        check_reset_vals("rst_mid");
        @(posedge clk); #1;
        check_reset_vals("rst_hold");
        pop = 0;
        reset = 1;
        #1;

        for (int i = 0; i < 3; i++) cycle("post_push", 1, 0, 12'h700 + 12'(i));
        for (int i = 0; i < 3; i++) cycle("post_pop", 0, 1, 12'h000);

        // Random traffic with biases that alternate so both full and empty are visited.
        wt_push = 50; wt_pop = 50;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                case ((i / 50) % 3)
                    0: begin wt_push = 80; wt_pop = 30; end
                    1: begin wt_push = 25; wt_pop = 80; end
                    default: begin wt_push = 50; wt_pop = 50; end
                endcase
            end
            cycle("rand", ($urandom_range(99) < wt_push), ($urandom_range(99) < wt_pop),
                  12'($urandom));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_control.md
# fifo_control

Pointer and flag controller that turns a push/pop request interface into the write/read/pointer signals of the 8-entry × 12-bit FIFO storage memory. It sits in front of the memory: it forwards write data, generates the `write`, `read`, `wr_ptr` and `rd_ptr` strobes, tracks occupancy, and re-times the memory's registered read data into a `data_out`/`valid_out` pair. Overflow and underflow attempts are blocked and flagged.

## Interface
- `DATA_WIDTH`, 12: word width; must match the memory.
- `ADDR_WIDTH`, 3: pointer width; depth = 2^ADDR_WIDTH = 8.
- `ALMOST_FULL`, 6: `almost_full` threshold (count ≥ value).
- `ALMOST_EMPTY`, 2: `almost_empty` threshold (count ≤ value).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `push`  in  1  request to enqueue `data_in` this cycle.
- `pop`  in  1  request to dequeue one word this cycle.
- `data_in`  in  DATA_WIDTH  word to enqueue.
- `q`  in  DATA_WIDTH  registered read data returned by the memory.
- `data`  out  DATA_WIDTH  write data to the memory (= `data_in`).
- `write`  out  1  memory write strobe.
- `read`  out  1  memory read strobe.
- `wr_ptr`  out  ADDR_WIDTH  memory write address.
- `rd_ptr`  out  ADDR_WIDTH  memory read address.
- `data_out`  out  DATA_WIDTH  dequeued word.
- `valid_out`  out  1  `data_out` holds a dequeued word this cycle.
- `fifo_count`  out  ADDR_WIDTH+1  current occupancy, 0..8.
- `full`, `empty`, `almost_full`, `almost_empty`  out  1 each  occupancy flags.
- `overflow`, `underflow`  out  1 each  sticky error flags.

## Operation
- Registered state: `wr_ptr`, `rd_ptr`, `fifo_count`, `valid_out`, `overflow`, `underflow`.
- Flags are decoded from the registered `fifo_count`:
  - `full` = (count == 8); `empty` = (count == 0).
  - `almost_full` = (count ≥ ALMOST_FULL); `almost_empty` = (count ≤ ALMOST_EMPTY).
- Acceptance is combinational from the current registered flags:
  - `write` = `push` & !`full`.
  - `read` = `pop` & !`empty`.
- Pointers:
  - `write` → `wr_ptr` increments mod 8 at the edge.
  - `read` → `rd_ptr` increments mod 8 at the edge.
  - 7 → 0 is a natural wrap.
- Count update: +1 on write only, −1 on read only, unchanged on both or neither.
- Simultaneous `push` and `pop`, each judged independently:
  - When full: pop accepted, push rejected, `overflow` set; count becomes 7.
  - When empty: push accepted, pop rejected, `underflow` set; count becomes 1.
  - Otherwise both accepted; count unchanged.
- Error flags:
  - `overflow` sets on `push` & `full`.
  - `underflow` sets on `pop` & `empty`.
  - Both are cleared only by reset.
- Rejected operations never move pointers or the count.
- `data` = `data_in`, combinational.
- Read path: `valid_out` is registered from `read`; `data_out` = `q`. Together they deliver the word read at `rd_ptr` in the previous cycle.
- Reset (asynchronous, any cycle, including mid-burst):
  - Pointers = 0, count = 0, `valid_out` = 0, `overflow` = `underflow` = 0.
  - Hence `empty` = 1, `almost_empty` = 1, `full` = 0, `almost_full` = 0.
  - `write` and `read` are 0 while reset is held.
  - Memory contents are not cleared; they are unreachable until rewritten.

## Timing
- `write` and `read` are valid in the same cycle as `push` and `pop`; the memory samples them at the next rising edge.
- Pointers, count, flags and error bits reflect an operation one cycle after the request edge.
- Pop latency: `pop` accepted in cycle N → `valid_out` = 1 and `data_out` = word in cycle N+1.
- Back-to-back pops yield one word per cycle.
- Push-to-pop: a word pushed in cycle N can be popped in cycle N+1, because `empty` deasserts after the edge.
- Occupancy is limited to 8. A full FIFO keeps accepting pops; an empty FIFO keeps accepting pushes.
- Reset deassertion is synchronized by the surrounding design; the first operation is permitted on the first edge after deassertion.

## Test plan
- Reset, then push 0x001..0x008 on 8 consecutive cycles. Required:
  - count reaches 8, `full` = 1.
  - `almost_full` rises when count reaches 6.
  - `wr_ptr` wraps to 0.
  - `overflow` stays 0.
- From full, push 0xABC with no pop. Required: `write` = 0, count stays 8, `overflow` = 1 and holds.
- Pop 8 times. Required:
  - `data_out` = 0x001..0x008 on consecutive cycles, each with `valid_out` = 1 one cycle after its pop.
  - `empty` = 1 at the end; `rd_ptr` = 0.
- While empty, assert push 0x5A5 and pop together. Required:
  - Push accepted, count = 1, `underflow` = 1.
  - A pop next cycle returns 0x5A5.
- Half full (count 4), hold push+pop for 10 cycles. Required:
  - Count stays 4 and both pointers wrap past 7.
  - Output data is in push order.
- Assert reset at count 5 during a pop. Required:
  - All registered outputs return to reset values immediately, `valid_out` = 0.
  - The next push/pop sequence behaves as if from power-up.
